// File: rtl/xrbus_frame_serializer.sv
// Captures one XR-BUS frame plus its 256-bit hash and streams it as header, body and hash beats
// on a 64-bit valid/ready link; one idle cycle separates consecutive frames.
module xrbus_frame_serializer #(
   parameter int FRAME_BEATS = 25
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [4095:0] frame_in,
   input  logic [255:0]  frame_hash_in,
   input  logic          frame_valid_in,
   output logic          frame_ready_out,
   output logic [63:0]   tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          tx_sof,
   output logic          tx_eof,
   output logic [15:0]   frames_sent
);

   localparam int         FW          = 64 * FRAME_BEATS;
   localparam logic [7:0] TOTAL_BEATS = 8'(FRAME_BEATS + 5);
   localparam logic [6:0] LAST_BODY   = 7'(FRAME_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      BODY,
      HASH
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    beat_q, beat_d;
   logic [15:0]   seq_q, seq_d;
   logic [15:0]   frames_sent_q, frames_sent_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [255:0]  hash_q, hash_d;
   logic          beat_hs;

   generate
      if (FW < 4096) begin : g_hi_bits
         logic unused_frame_hi;
         assign unused_frame_hi = ^frame_in[4095:FW];
      end
   endgenerate

   assign frame_ready_out = (state_q == IDLE);
   assign tx_valid        = (state_q != IDLE);
   assign tx_sof          = (state_q == HDR);
   assign tx_eof          = (state_q == HASH) && (beat_q == 7'd3);
   assign beat_hs         = tx_valid && tx_ready;
   assign frames_sent     = frames_sent_q;

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      seq_d         = seq_q;
      frames_sent_d = frames_sent_q;
      frame_d       = frame_q;
      hash_d        = hash_q;
      case (state_q)
         IDLE: begin
            if (frame_valid_in) begin
               frame_d = frame_in[FW-1:0];
               hash_d  = frame_hash_in;
               beat_d  = '0;
               state_d = HDR;
            end
         end
         HDR: begin
            if (beat_hs) begin
               beat_d  = '0;
               state_d = BODY;
            end
         end
         BODY: begin
            if (beat_hs) begin
               if (beat_q == LAST_BODY) begin
                  beat_d  = '0;
                  state_d = HASH;
               end else begin
                  beat_d = beat_q + 7'd1;
               end
            end
         end
         HASH: begin
            if (beat_hs) begin
               if (beat_q == 7'd3) begin
                  beat_d        = '0;
                  seq_d         = seq_q + 16'd1;
                  frames_sent_d = frames_sent_q + 16'd1;
                  state_d       = IDLE;
               end else begin
                  beat_d = beat_q + 7'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output mux depends only on registered state, so it holds steady across stalls.
   always_comb begin
      tx_data = '0;
      case (state_q)
         HDR: tx_data = {16'h5852, seq_q, TOTAL_BEATS, 24'h0};
         BODY: begin
            for (int k = 0; k < FRAME_BEATS; k++) begin
               if (beat_q == 7'(k)) tx_data = frame_q[64*k +: 64];
            end
         end
         HASH: begin
            for (int j = 0; j < 4; j++) begin
               if (beat_q == 7'(j)) tx_data = hash_q[64*j +: 64];
            end
         end
         default: tx_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         seq_q         <= '0;
         frames_sent_q <= '0;
         frame_q       <= '0;
         hash_q        <= '0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         seq_q         <= seq_d;
         frames_sent_q <= frames_sent_d;
         frame_q       <= frame_d;
         hash_q        <= hash_d;
      end
   end

endmodule

// File: tb/tb_xrbus_frame_serializer.sv
// Bench for xrbus_frame_serializer: queue-based beat model plus vector tables and corner sequences.
module tb_xrbus_frame_serializer;

   localparam int FB = 25;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4095:0] frame_in;
   logic [255:0]  frame_hash_in;
   logic          frame_valid_in;
   logic          frame_ready_out;
   logic [63:0]   tx_data;
   logic          tx_valid, tx_ready, tx_sof, tx_eof;
   logic [15:0]   frames_sent;

   logic [4095:0] f1_in;
   logic [255:0]  h1_in;
   logic          f1_vld, f1_rdy;
   logic [63:0]   tx1_data;
   logic          tx1_valid, tx1_ready, tx1_sof, tx1_eof;
   logic [15:0]   sent1;

   always #5 clk = ~clk;

   xrbus_frame_serializer #(.FRAME_BEATS(FB)) dut (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_hash_in(frame_hash_in),
      .frame_valid_in(frame_valid_in), .frame_ready_out(frame_ready_out),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_sof(tx_sof), .tx_eof(tx_eof), .frames_sent(frames_sent));

   xrbus_frame_serializer #(.FRAME_BEATS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_in(f1_in), .frame_hash_in(h1_in),
      .frame_valid_in(f1_vld), .frame_ready_out(f1_rdy),
      .tx_data(tx1_data), .tx_valid(tx1_valid), .tx_ready(tx1_ready),
      .tx_sof(tx1_sof), .tx_eof(tx1_eof), .frames_sent(sent1));

   typedef struct {
      logic [63:0] data;
      bit          sof;
      bit          eof;
   } beat_t;

   typedef struct {
      int          idx;
      logic [63:0] data;
      bit          sof;
      bit          eof;
   } vec_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    obs_cyc[$];
   beat_t b1[$];
   beat_t prev;
   beat_t e;
   vec_t  tbl[7];
   vec_t  tbl1[4];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int acc_cyc = 0;
   bit chk_on = 1'b0;
   bit prev_stall = 1'b0;
   logic [15:0] m_seq = '0;
   logic [15:0] m_sent = '0;
   logic [15:0] seq_a;

   logic          n_rst = 1'b0;
   logic [4095:0] n_frame = '0;
   logic [255:0]  n_hash = '0;
   logic          n_fvld = 1'b0;
   logic          n_rdy = 1'b0;
   logic [4095:0] fr;
   logic [255:0]  hs;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [4095:0] rnd4k();
      logic [4095:0] r;
      for (int i = 0; i < 128; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Reference: a frame is a header word, FB body words, then four hash words.
   task automatic push_frame(input logic [4095:0] f, input logic [255:0] h, input logic [15:0] s);
      exp_q.push_back('{{16'h5852, s, 8'(FB + 5), 24'h0}, 1'b1, 1'b0});
      for (int k = 0; k < FB; k++) exp_q.push_back('{f[64*k +: 64], 1'b0, 1'b0});
      for (int j = 0; j < 4; j++) exp_q.push_back('{h[64*j +: 64], 1'b0, (j == 3)});
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (chk_on) begin
         if (prev_stall) begin
            chk("stall_valid", 64'(tx_valid), 64'(1'b1));
            chk("stall_data", tx_data, prev.data);
            chk("stall_sof", 64'(tx_sof), 64'(prev.sof));
            chk("stall_eof", 64'(tx_eof), 64'(prev.eof));
         end
         chk("frames_sent", 64'(frames_sent), 64'(m_sent));
         chk("valid_vs_ready", 64'(tx_valid), 64'(!frame_ready_out));
      end
      rst_n          = n_rst;
      frame_in       = n_frame;
      frame_hash_in  = n_hash;
      frame_valid_in = n_fvld;
      tx_ready       = n_rdy;
      prev           = '{tx_data, tx_sof, tx_eof};
      prev_stall     = tx_valid && !tx_ready && n_rst;
      if (!n_rst) begin
         exp_q.delete();
         m_seq  = '0;
         m_sent = '0;
      end else begin
         if (tx_valid && tx_ready) begin
            obs_q.push_back(prev);
            obs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h, want no beat", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", tx_data, e.data);
               chk("beat_sof", 64'(tx_sof), 64'(e.sof));
               chk("beat_eof", 64'(tx_eof), 64'(e.eof));
               if (e.eof) begin
                  m_seq++;
                  m_sent++;
               end
            end
         end
         if (frame_valid_in && frame_ready_out) begin
            push_frame(frame_in, frame_hash_in, m_seq);
            acc_cyc = cyc;
         end
      end
   endtask

   task automatic drain(input int cap, input int mode);
      int i;
      i = 0;
      while (!(exp_q.size() == 0 && frame_ready_out === 1'b1) && i < cap) begin
         case (mode)
            0:       n_rdy = 1'b1;
            1:       n_rdy = (i % 4 == 0) || (i % 4 == 3);
            default: n_rdy = ($urandom_range(0, 3) != 0);
         endcase
         tick();
         i++;
      end
      n_cmp++;
      if (i >= cap) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats still pending, want 0", exp_q.size());
      end
   endtask

   task automatic send(input logic [4095:0] f, input logic [255:0] h, input int mode);
      n_frame = f;
      n_hash  = h;
      n_fvld  = 1'b1;
      n_rdy   = 1'b1;
      tick();
      n_fvld = 1'b0;
      drain(400, mode);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; frame_in = '0; frame_hash_in = '0; frame_valid_in = 1'b0; tx_ready = 1'b0;
      f1_in = '0; h1_in = '0; f1_vld = 1'b0; tx1_ready = 1'b0;

      // Reset values
      repeat (3) tick();
      n_rst = 1'b1;
      tick();
      chk("rst_ready", 64'(frame_ready_out), 64'(1'b1));
      chk("rst_valid", 64'(tx_valid), 64'(1'b0));
      chk("rst_sof", 64'(tx_sof), 64'(1'b0));
      chk("rst_eof", 64'(tx_eof), 64'(1'b0));
      chk("rst_data", tx_data, 64'h0);
      chk("rst_frames_sent", 64'(frames_sent), 64'h0);
      chk_on = 1'b1;

      // Single frame, table of spot-checked beats
      fr = rnd4k();
      fr[63:0] = 64'h0123_4567_89AB_CDEF;
      hs = rnd256();
      hs[255:192] = 64'hDEAD_BEEF_0000_0001;
      obs_q.delete(); obs_cyc.delete();
      send(fr, hs, 0);
      tbl[0] = '{0,  64'h5852_0000_1E00_0000, 1'b1, 1'b0};
      tbl[1] = '{1,  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
      tbl[2] = '{2,  fr[127:64],              1'b0, 1'b0};
      tbl[3] = '{25, fr[64*24 +: 64],         1'b0, 1'b0};
      tbl[4] = '{26, hs[63:0],                1'b0, 1'b0};
      tbl[5] = '{28, hs[191:128],             1'b0, 1'b0};
      tbl[6] = '{29, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1};
      chk("single_beat_count", 64'(obs_q.size()), 64'd30);
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].idx < obs_q.size()) begin
            chk($sformatf("single_data[%0d]", tbl[i].idx), obs_q[tbl[i].idx].data, tbl[i].data);
            chk($sformatf("single_sof[%0d]", tbl[i].idx), 64'(obs_q[tbl[i].idx].sof), 64'(tbl[i].sof));
            chk($sformatf("single_eof[%0d]", tbl[i].idx), 64'(obs_q[tbl[i].idx].eof), 64'(tbl[i].eof));
         end else begin
            n_cmp++; n_fail++;
            $display("FAIL single_missing[%0d]: got %0d beats, want more", tbl[i].idx, obs_q.size());
         end
      end
      if (obs_q.size() == 30) begin
         chk("single_latency", 64'(obs_cyc[0] - acc_cyc), 64'd1);
         chk("single_contiguous", 64'(obs_cyc[29] - obs_cyc[0]), 64'd29);
      end
      tick();
      chk("single_frames_sent", 64'(frames_sent), 64'd1);

      // Backpressure 1,0,0,1
      obs_q.delete(); obs_cyc.delete();
      send(rnd4k(), rnd256(), 1);
      chk("bp_beat_count", 64'(obs_q.size()), 64'd30);

      // Back-to-back with valid held high and inputs changing mid-frame
      obs_q.delete(); obs_cyc.delete();
      seq_a   = m_seq;
      n_frame = rnd4k(); n_hash = rnd256(); n_fvld = 1'b1; n_rdy = 1'b1;
      tick();
      n_frame = rnd4k(); n_hash = rnd256();
      repeat (32) tick();
      n_fvld = 1'b0;
      drain(200, 0);
      chk("b2b_beat_count", 64'(obs_q.size()), 64'd60);
      if (obs_q.size() >= 31) begin
         chk("b2b_eof_first", 64'(obs_q[29].eof), 64'(1'b1));
         chk("b2b_sof_second", 64'(obs_q[30].sof), 64'(1'b1));
         chk("b2b_gap", 64'(obs_cyc[30] - obs_cyc[29]), 64'd2);
         chk("b2b_seq", 64'(obs_q[30].data[47:32]), 64'(seq_a + 16'd1));
      end

      // Random frames, random valid and ready
      for (int i = 0; i < 400; i++) begin
         n_frame = rnd4k();
         n_hash  = rnd256();
         n_fvld  = 1'($urandom_range(0, 1));
         n_rdy   = ($urandom_range(0, 3) != 0);
         tick();
      end
      n_fvld = 1'b0;
      drain(600, 2);

      // Sequence wrap
      force dut.seq_q = 16'hFFFF;
      force dut.frames_sent_q = 16'hFFFF;
      #1;
      release dut.seq_q;
      release dut.frames_sent_q;
      m_seq  = 16'hFFFF;
      m_sent = 16'hFFFF;
      obs_q.delete(); obs_cyc.delete();
      send(rnd4k(), rnd256(), 2);
      if (obs_q.size() > 0) chk("wrap_seq_ffff", 64'(obs_q[0].data[47:32]), 64'hFFFF);
      chk("wrap_frames_sent0", 64'(frames_sent), 64'h0);
      obs_q.delete(); obs_cyc.delete();
      send(rnd4k(), rnd256(), 0);
      if (obs_q.size() > 0) chk("wrap_seq_0000", 64'(obs_q[0].data[47:32]), 64'h0);
      chk("wrap_frames_sent1", 64'(frames_sent), 64'h1);

      // Reset on body beat 10
      n_rst = 1'b0; tick();
      n_rst = 1'b1; tick();
      fr = rnd4k();
      n_frame = fr; n_hash = rnd256(); n_fvld = 1'b1; n_rdy = 1'b1;
      tick();
      n_fvld = 1'b0;
      repeat (11) tick();
      n_rst = 1'b0;
      tick();
      chk("abort_on_body10", prev.data, fr[64*10 +: 64]);
      n_rst = 1'b1;
      tick();
      chk("abort_valid", 64'(tx_valid), 64'(1'b0));
      chk("abort_ready", 64'(frame_ready_out), 64'(1'b1));
      obs_q.delete(); obs_cyc.delete();
      send(rnd4k(), rnd256(), 0);
      if (obs_q.size() > 0) begin
         chk("abort_next_sof", 64'(obs_q[0].sof), 64'(1'b1));
         chk("abort_next_seq", 64'(obs_q[0].data[47:32]), 64'h0);
      end

      // Single-body-beat instance
      @(negedge clk);
      f1_in = rnd4k(); h1_in = rnd256(); f1_vld = 1'b1; tx1_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         f1_vld = 1'b0;
         if (tx1_valid) b1.push_back('{tx1_data, tx1_sof, tx1_eof});
      end
      tbl1[0] = '{0, 64'h5852_0000_0600_0000, 1'b1, 1'b0};
      tbl1[1] = '{1, f1_in[63:0],             1'b0, 1'b0};
      tbl1[2] = '{2, h1_in[63:0],             1'b0, 1'b0};
      tbl1[3] = '{5, h1_in[255:192],          1'b0, 1'b1};
      chk("fb1_beat_count", 64'(b1.size()), 64'd6);
      for (int i = 0; i < 4; i++) begin
         if (tbl1[i].idx < b1.size()) begin
            chk($sformatf("fb1_data[%0d]", tbl1[i].idx), b1[tbl1[i].idx].data, tbl1[i].data);
            chk($sformatf("fb1_sof[%0d]", tbl1[i].idx), 64'(b1[tbl1[i].idx].sof), 64'(tbl1[i].sof));
            chk($sformatf("fb1_eof[%0d]", tbl1[i].idx), 64'(b1[tbl1[i].idx].eof), 64'(tbl1[i].eof));
         end else begin
            n_cmp++; n_fail++;
            $display("FAIL fb1_missing[%0d]: got %0d beats, want more", tbl1[i].idx, b1.size());
         end
      end
      chk("fb1_frames_sent", 64'(sent1), 64'd1);
      chk("fb1_ready", 64'(f1_rdy), 64'(1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
